tile_dispatcher: RTL and testbench
==================================

# tile_dispatcher

Frame-level tile scheduler for the ray-tracing renderer. It splits the screen into fixed-size tiles and hands them round-robin to `NUM_CORES` parallel ray cores. It tracks outstanding work, then synchronises the buffer flip to the display vsync. It generalises the single-core renderer frame loop (render, wait vsync, flip) to configurable resolution, tile size and core count.

## Interface
Parameters:
- `SCREEN_W`, 320, screen width in pixels; must be a multiple of `TILE_W`
- `SCREEN_H`, 240, screen height in pixels; must be a multiple of `TILE_H`
- `TILE_W`, 16, tile width in pixels
- `TILE_H`, 16, tile height in pixels
- `NUM_CORES`, 4, number of ray cores, 1..16

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  level; allows a new frame to start
- `vsync`  in  1  display vsync level; the rising edge is used
- `core_ready`  in  NUM_CORES  core i is idle and can accept a tile
- `core_start`  out  NUM_CORES  one-hot, one-cycle pulse assigning the current tile to core i
- `tile_x`  out  $clog2(SCREEN_W)  pixel x origin of the assigned tile; valid while `core_start` != 0
- `tile_y`  out  $clog2(SCREEN_H)  pixel y origin of the assigned tile; valid while `core_start` != 0
- `core_done`  in  NUM_CORES  one-cycle pulse per finished tile; any number of bits may be set in one cycle
- `flip`  out  1  one-cycle pulse; swap front and back buffers
- `back_buffer`  out  1  index of the buffer being rendered
- `frame_count`  out  16  number of completed flips, wraps at 65535 -> 0
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, DISPATCH, DRAIN, WAIT_VSYNC, FLIP.
- IDLE: if `enable` is high, clear the tile cursor and go to DISPATCH next cycle.
- DISPATCH, per cycle:
  - The arbiter picks one ready core (round-robin, starting after the last granted core).
  - Pulse its `core_start` bit with the current `tile_x`/`tile_y`.
  - Advance the cursor: x += TILE_W; at the end of a row, x = 0 and y += TILE_H.
  - If no core is ready, nothing is issued.
  - After the last tile (x = SCREEN_W−TILE_W, y = SCREEN_H−TILE_H) is issued, go to DRAIN.
- Outstanding counter, width $clog2(NUM_CORES+1):
  - +1 per start; −popcount(`core_done`) per cycle.
  - A start and done(s) in the same cycle net together.
  - A done with the counter at 0 is ignored (counter saturates at 0).
- DRAIN: when the counter reaches 0, go to WAIT_VSYNC.
- WAIT_VSYNC: a vsync rising edge (`vsync` high, registered previous value low) sampled in this state moves to FLIP. Edges seen in any other state are discarded, so a slow frame delays the flip rather than tearing.
- FLIP (one cycle):
  - `flip` = 1.
  - `back_buffer` toggles and `frame_count` increments, visible on the next cycle.
  - Next state: DISPATCH if `enable` is high, else IDLE.
- `enable` low only stops new frames; a frame in progress always completes through FLIP.
- Grant ordering: the round-robin pointer persists across frames; it is reset to core 0.

## Timing
- Reset values:
  - state IDLE
  - `core_start` = 0, `tile_x` = 0, `tile_y` = 0
  - `flip` = 0, `back_buffer` = 0, `frame_count` = 0, `busy` = 0
  - counter = 0, round-robin pointer = 0, vsync history = 0
- All outputs are registered.
- Dispatch: a `core_ready` bit sampled high in cycle n gives `core_start` in cycle n+1. At most one start per cycle.
- A core must drop `core_ready` in the cycle after its `core_start`; the dispatcher does not re-check this.
- With all cores always ready, a frame issues one tile per cycle; total tiles = (SCREEN_W/TILE_W)·(SCREEN_H/TILE_H).
- Vsync: `flip` is high exactly one cycle, in the cycle after the sampled edge.
- Reset mid-frame aborts immediately. Pending `core_done` pulses after reset are ignored by the saturating counter.

## Structure
- Package `tile_dispatcher_pkg`:
  - state enum `TileDispatchState`
  - localparams TILES_X, TILES_Y, CNT_W
- Sub-module `rr_arbiter`: parametric `NUM_CORES` round-robin one-hot grant with pointer update on grant. Reused by the memory controller request mux.

## Test plan
Configuration for all cases: 64×32 screen, 16×16 tiles (8 tiles), `NUM_CORES`=2.
- **Full-rate dispatch:** all ready, `enable`=1 -> 8 starts on consecutive cycles alternating core0/core1, coordinates (0,0),(16,0),(32,0),(48,0),(0,16)…(48,16); then DRAIN.
- **Completion and flip:** return done pulses, including a cycle with both done bits plus a new start -> counter correct; 0 reached -> WAIT_VSYNC. Vsync edge -> `flip` one cycle later, `back_buffer`=1, `frame_count`=1.
- **Early vsync:** vsync edges during DISPATCH/DRAIN -> no flip; `flip` only on the first edge after WAIT_VSYNC is entered.
- **Backpressure:** only core1 ready for 20 cycles -> all starts go to core1, with idle gaps while core1 is not ready; tile order preserved.
- **Enable drop:** `enable`=0 mid-frame -> frame finishes, flip occurs, state IDLE, `busy`=0. Re-assert -> new frame starts at tile (0,0).
- **Reset mid-DRAIN:** all outputs return to reset values next cycle; stray `core_done` afterward leaves the counter at 0.

Source files
------------

// File: rtl/tile_dispatcher_pkg.sv
// Shared types and default geometry for the tile dispatcher.
package tile_dispatcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_WAIT_VSYNC,
    ST_FLIP
  } TileDispatchState;

  localparam int DEF_SCREEN_W  = 320;
  localparam int DEF_SCREEN_H  = 240;
  localparam int DEF_TILE_W    = 16;
  localparam int DEF_TILE_H    = 16;
  localparam int DEF_NUM_CORES = 4;

  localparam int TILES_X = DEF_SCREEN_W / DEF_TILE_W;
  localparam int TILES_Y = DEF_SCREEN_H / DEF_TILE_H;
  localparam int CNT_W   = $clog2(DEF_NUM_CORES + 1);

  // Outstanding counter width for a given core count (must hold 0..n).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tile_dispatcher_rr_arbiter.sv
// Round-robin one-hot arbiter; priority starts at the core after the last grant.
module rr_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 en,
  output logic [NUM_CORES-1:0] grant,
  output logic                 valid
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  int               idx;

  // Scan requests starting at the pointer and grant the first one found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_CORES; off++) begin
      idx = (int'(ptr) + off) % NUM_CORES;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  // Move priority to the core just after the one granted, only when the grant is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && valid) begin
      ptr <= (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tile_dispatcher.sv
// Frame-level tile scheduler: dispatches tiles round-robin to ray cores,
// waits for all work to retire, then flips buffers on the next vsync edge.
module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int TILE_W    = DEF_TILE_W,
  parameter int TILE_H    = DEF_TILE_H,
  parameter int NUM_CORES = DEF_NUM_CORES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        vsync,
  input  logic [NUM_CORES-1:0]        core_ready,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [$clog2(SCREEN_W)-1:0] tile_x,
  output logic [$clog2(SCREEN_H)-1:0] tile_y,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic                        flip,
  output logic                        back_buffer,
  output logic [15:0]                 frame_count,
  output logic                        busy
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int CW = cnt_width(NUM_CORES);

  localparam logic [XW-1:0] LAST_X = XW'(SCREEN_W - TILE_W);
  localparam logic [YW-1:0] LAST_Y = YW'(SCREEN_H - TILE_H);
  localparam logic [XW-1:0] STEP_X = XW'(TILE_W);
  localparam logic [YW-1:0] STEP_Y = YW'(TILE_H);

  TileDispatchState state, next_state;

  logic [XW-1:0]        cur_x;
  logic [YW-1:0]        cur_y;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        outstanding_next;
  logic                 vsync_q;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_valid;
  logic                 issue;
  logic                 last_tile;
  logic                 vsync_rise;
  int                   cnt_calc;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (core_ready),
    .en   (state == ST_DISPATCH),
    .grant(grant),
    .valid(grant_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic plus the per-cycle issue and edge-detect decisions.
  always_comb begin
    next_state = state;
    issue      = (state == ST_DISPATCH) && grant_valid;
    last_tile  = (cur_x == LAST_X) && (cur_y == LAST_Y);
    vsync_rise = vsync && !vsync_q;
    case (state)
      ST_IDLE:       if (enable) next_state = ST_DISPATCH;
      ST_DISPATCH:   if (issue && last_tile) next_state = ST_DRAIN;
      ST_DRAIN:      if (outstanding == '0) next_state = ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: if (vsync_rise) next_state = ST_FLIP;
      ST_FLIP:       next_state = enable ? ST_DISPATCH : ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // Outstanding tiles: one up per start, down per done bit, never below zero.
  always_comb begin
    cnt_calc = int'(outstanding) + (issue ? 1 : 0) - $countones(core_done);
    if (cnt_calc < 0) cnt_calc = 0;
    outstanding_next = CW'(cnt_calc);
  end

  // Registered outputs, tile cursor, counter and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_start  <= '0;
      tile_x      <= '0;
      tile_y      <= '0;
      flip        <= 1'b0;
      back_buffer <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      outstanding <= '0;
      vsync_q     <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      outstanding <= outstanding_next;
      core_start  <= issue ? grant : '0;
      flip        <= (next_state == ST_FLIP);
      busy        <= (next_state != ST_IDLE);
      if (state == ST_IDLE || state == ST_FLIP) begin
        cur_x <= '0;
        cur_y <= '0;
      end else if (issue) begin
        tile_x <= cur_x;
        tile_y <= cur_y;
        if (cur_x == LAST_X) begin
          cur_x <= '0;
          cur_y <= cur_y + STEP_Y;
        end else begin
          cur_x <= cur_x + STEP_X;
        end
      end
      if (state == ST_FLIP) begin
        back_buffer <= ~back_buffer;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tile_dispatcher.sv
// Directed bench for tile_dispatcher on a 64x32 screen, 16x16 tiles, two cores.
module tb_tile_dispatcher;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       vsync;
  logic [1:0] core_ready;
  logic [1:0] core_start;
  logic [5:0] tile_x;
  logic [4:0] tile_y;
  logic [1:0] core_done;
  logic       flip;
  logic       back_buffer;
  logic [15:0] frame_count;
  logic       busy;

  tile_dispatcher #(
    .SCREEN_W (64),
    .SCREEN_H (32),
    .TILE_W   (16),
    .TILE_H   (16),
    .NUM_CORES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .vsync      (vsync),
    .core_ready (core_ready),
    .core_start (core_start),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .core_done  (core_done),
    .flip       (flip),
    .back_buffer(back_buffer),
    .frame_count(frame_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } tile_t;

  tile_t      sb[$];
  tile_t      popped;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         rr_ptr   = 0;
  int         start_total = 0;
  int         flip_total  = 0;
  int         gsel;
  logic [1:0] exp_grant;
  logic [1:0] ready_at_edge = 2'b00;
  logic       flip_prev = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [1:0] r, input logic [1:0] d);
    enable     = e;
    vsync      = v;
    core_ready = r;
    core_done  = d;
    @(negedge clk);
  endtask

  task automatic push_frame();
    tile_t t;
    for (int i = 0; i < 8; i++) begin
      t.x = 6'((i % 4) * 16);
      t.y = 5'((i / 4) * 16);
      sb.push_back(t);
    end
  endtask

  // Capture what the arbiter saw at each edge; reset clears the reference model.
  always @(posedge clk) begin
    ready_at_edge <= core_ready;
    if (reset) begin
      rr_ptr = 0;
      sb.delete();
    end
  end

  // Scoreboard: every start is matched against round-robin choice and tile order.
  always @(negedge clk) begin
    if (core_start != 2'b00) begin
      exp_grant = 2'b00;
      gsel = -1;
      for (int off = 0; off < 2; off++) begin
        if (gsel < 0 && ready_at_edge[(rr_ptr + off) % 2]) gsel = (rr_ptr + off) % 2;
      end
      if (gsel >= 0) begin
        exp_grant[gsel] = 1'b1;
        rr_ptr = (gsel + 1) % 2;
      end
      checkOutput("grant", 32'(core_start), 32'(exp_grant));
      if (sb.size() == 0) begin
        checkOutput("unexpected_start", 32'(sb.size()), 32'd1);
      end else begin
        popped = sb.pop_front();
        checkOutput("tile_x", 32'(tile_x), 32'(popped.x));
        checkOutput("tile_y", 32'(tile_y), 32'(popped.y));
      end
      start_total++;
    end
    if (flip) begin
      flip_total++;
      checkOutput("flip_width", 32'(flip_prev), 32'd0);
    end
    flip_prev = flip;
  end

  int         ns;
  int         wait1;
  logic [1:0] d;
  logic [1:0] r;
  logic       saw_core0;

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00);
    $display("[TB] reset values");
    checkOutput("rst_core_start", 32'(core_start), 32'd0);
    checkOutput("rst_tile_x", 32'(tile_x), 32'd0);
    checkOutput("rst_tile_y", 32'(tile_y), 32'd0);
    checkOutput("rst_flip", 32'(flip), 32'd0);
    checkOutput("rst_back_buffer", 32'(back_buffer), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_outstanding", 32'(dut.outstanding), 32'd0);
    reset = 1'b0;

    $display("[TB] frame 1: full-rate dispatch, early vsync, double done");
    push_frame();
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00);
    checkOutput("f1_busy", 32'(busy), 32'd1);
    ns = 0;
    for (int k = 0; k < 9; k++) begin
      d = core_start;
      if (core_start != 2'b00) ns++;
      if (ns == 5 && core_start != 2'b00) d = 2'b00;
      else if (ns == 6 && core_start != 2'b00) d = 2'b11;
      applyStimulus(1'b1, (k >= 2 && k < 4) || k >= 8, 2'b11, d);
      if (k == 5) checkOutput("f1_outstanding_2", 32'(dut.outstanding), 32'd2);
      if (k == 6) checkOutput("f1_outstanding_net", 32'(dut.outstanding), 32'd1);
      if (k == 7) checkOutput("f1_consecutive", 32'(ns), 32'd7);
    end
    checkOutput("f1_starts", 32'(ns), 32'd8);
    checkOutput("f1_drained", 32'(dut.outstanding), 32'd0);
    checkOutput("f1_sb_empty", 32'(sb.size()), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00);
    checkOutput("early_vsync_no_flip", 32'(flip_total), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b00);
    checkOutput("f1_flip", 32'(flip), 32'd1);
    checkOutput("f1_bb_before", 32'(back_buffer), 32'd0);
    checkOutput("f1_fc_before", 32'(frame_count), 32'd0);

    $display("[TB] frame 2: backpressure on core1, enable dropped mid-frame");
    push_frame();
    ns = 0;
    wait1 = 0;
    saw_core0 = 1'b0;
    for (int k = 0; k < 28; k++) begin
      d = 2'b00;
      if (core_start[0]) saw_core0 = 1'b1;
      if (core_start[1]) begin
        ns++;
        wait1 = 3;
      end
      if (wait1 > 0) begin
        wait1--;
        if (wait1 == 0) d = 2'b10;
      end
      r = (wait1 == 0) ? 2'b10 : 2'b00;
      applyStimulus(k < 5, 1'b0, r, d);
      if (k == 0) begin
        checkOutput("f1_flip_gone", 32'(flip), 32'd0);
        checkOutput("f1_bb_after", 32'(back_buffer), 32'd1);
        checkOutput("f1_fc_after", 32'(frame_count), 32'd1);
      end
    end
    checkOutput("f2_starts", 32'(ns), 32'd8);
    checkOutput("f2_no_core0", 32'(saw_core0), 32'd0);
    checkOutput("f2_drained", 32'(dut.outstanding), 32'd0);
    checkOutput("f2_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("f2_still_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00);
    checkOutput("f2_flip", 32'(flip), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00);
    checkOutput("f2_idle_busy", 32'(busy), 32'd0);
    checkOutput("f2_fc", 32'(frame_count), 32'd2);
    checkOutput("f2_bb", 32'(back_buffer), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b11, 2'b00);
    checkOutput("idle_no_start", 32'(core_start), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] frame 3: restart at origin, reset during drain");
    push_frame();
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00);
    ns = 0;
    for (int k = 0; k < 9; k++) begin
      d = core_start;
      if (core_start != 2'b00) ns++;
      if (ns == 8 && core_start != 2'b00) d = 2'b00;
      applyStimulus(1'b1, 1'b0, 2'b11, d);
    end
    checkOutput("f3_starts", 32'(ns), 32'd8);
    checkOutput("f3_pending", 32'(dut.outstanding), 32'd1);
    checkOutput("f3_sb_empty", 32'(sb.size()), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00);
    checkOutput("mid_rst_core_start", 32'(core_start), 32'd0);
    checkOutput("mid_rst_tile_x", 32'(tile_x), 32'd0);
    checkOutput("mid_rst_tile_y", 32'(tile_y), 32'd0);
    checkOutput("mid_rst_flip", 32'(flip), 32'd0);
    checkOutput("mid_rst_bb", 32'(back_buffer), 32'd0);
    checkOutput("mid_rst_fc", 32'(frame_count), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_outstanding", 32'(dut.outstanding), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b11);
    checkOutput("stray_done_sat", 32'(dut.outstanding), 32'd0);
    checkOutput("stray_done_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b01);
    checkOutput("stray_done_sat2", 32'(dut.outstanding), 32'd0);

    checkOutput("total_starts", 32'(start_total), 32'd24);
    checkOutput("total_flips", 32'(flip_total), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
